// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the serial BCD adder
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam logic [4:0] BCD_BASE    = 5'd10;

endpackage

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - combinational one-digit BCD adder with decimal carry
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       c,
    output logic [3:0] d0,
    output logic [3:0] d1
);

    logic [4:0] w_t;
    logic [3:0] w_adj;

    // Binary sum, then wrap into decimal; invalid digits follow the same rule
    always_comb begin
        w_t   = {1'b0, x} + {1'b0, y} + {4'b0000, c};
        w_adj = 4'(w_t - BCD_BASE);
        if (w_t >= BCD_BASE) begin
            d0 = w_adj;
            d1 = 4'd1;
        end else begin
            d0 = w_t[3:0];
            d1 = 4'd0;
        end
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// rtl/bcd_serial_add_ctrl.sv - digit-serial packed-BCD adder controller
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter  int NDIGITS = 4,
    localparam int IDXW    = $clog2(NDIGITS) + 1,
    localparam int W       = 4 * NDIGITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         err
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_carry;
    logic [IDXW-1:0] r_idx;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            r_err;

    logic [3:0]      w_xa;
    logic [3:0]      w_xb;
    logic [3:0]      w_d0;
    logic [3:0]      w_d1;
    logic            w_last;
    logic            w_bad_digit;
    logic [2:0]      w_unused_d1;

    assign w_xa        = r_a[BCD_DIGIT_W-1:0];
    assign w_xb        = r_b[BCD_DIGIT_W-1:0];
    assign w_last      = (r_idx == IDXW'(NDIGITS - 1));
    assign w_bad_digit = (w_xa > BCD_MAX) | (w_xb > BCD_MAX);
    assign w_unused_d1 = w_d1[3:1];

    bcd_digit_add u_digit_add (
        .x  (w_xa),
        .y  (w_xb),
        .c  (r_carry),
        .d0 (w_d0),
        .d1 (w_d1)
    );

    // Next-state: start only matters in IDLE; RUN ends after the top digit
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Datapath: latch operands on accept, then consume one digit per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                RUN: begin
                    r_sum[r_idx*BCD_DIGIT_W +: BCD_DIGIT_W] <= w_d0;
                    r_carry <= w_d1[0];
                    r_a     <= r_a >> BCD_DIGIT_W;
                    r_b     <= r_b >> BCD_DIGIT_W;
                    r_idx   <= r_idx + 1'b1;
                    r_err   <= r_err | w_bad_digit;
                    if (w_last) r_cout <= w_d1[0];
                end
                default: ;
            endcase
        end
    end

    assign ready = (r_state == IDLE);
    assign busy  = (r_state == RUN);
    assign done  = (r_state == DONE);
    assign sum   = r_sum;
    assign cout  = r_cout;
    assign err   = r_err;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb/tb_bcd_serial_add_ctrl.sv - scoreboard bench for bcd_serial_add_ctrl
module tb_bcd_serial_add_ctrl;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        ready, busy, done, cout, err;
    logic [15:0] sum;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    bcd_serial_add_ctrl #(.NDIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
    );

    function automatic int from_bcd(input logic [15:0] v);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        int t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic exp_t model(input logic [15:0] va, input logic [15:0] vb, input logic vc);
        exp_t e;
        int s = from_bcd(va) + from_bcd(vb) + int'(vc);
        e.sum  = to_bcd(s % 10000);
        e.cout = (s >= 10000);
        e.err  = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [15:0] s, input logic c, input logic e);
        exp_t r;
        r.sum = s; r.cout = c; r.err = e;
        return r;
    endfunction

    task automatic launch(input logic [15:0] va, input logic [15:0] vb, input logic vc, input exp_t e);
        @(negedge clk);
        a = va; b = vb; cin = vc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(output int cyc, output int bcnt, output bit to);
        cyc = 0; bcnt = 0; to = 1'b0;
        while (done !== 1'b1) begin
            if (busy === 1'b1) bcnt++;
            if (cyc >= 50) begin
                to = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else n_pass++;
        n_chk++; if ({busy, done, cout, err} !== 4'b0000) $display("FAIL reset_flags got %b want 0000", {busy, done, cout, err}); else n_pass++;
        n_chk++; if (sum !== 16'h0000) $display("FAIL reset_sum got %h want 0000", sum); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        exp_t e; int cyc, bcnt; bit to;
        launch(16'h1234, 16'h5678, 1'b0, mk(16'h6912, 1'b0, 1'b0));
        wait_done(cyc, bcnt, to);
        e = exp_q.pop_front();
        n_chk++; if (to) $display("FAIL basic_timeout no done within 50 cycles"); else n_pass++;
        n_chk++; if (cyc !== 4) $display("FAIL basic_latency got %0d want 4 cycles after first RUN sample", cyc); else n_pass++;
        n_chk++; if (bcnt !== 4) $display("FAIL basic_busy_cycles got %0d want 4", bcnt); else n_pass++;
        n_chk++; if (sum !== e.sum) $display("FAIL basic_sum got %h want %h", sum, e.sum); else n_pass++;
        n_chk++; if ({cout, err} !== {e.cout, e.err}) $display("FAIL basic_cout_err got %b want %b", {cout, err}, {e.cout, e.err}); else n_pass++;
        n_chk++; if ({ready, busy} !== 2'b00) $display("FAIL basic_exclusive got ready/busy %b want 00", {ready, busy}); else n_pass++;
        @(negedge clk);
        n_chk++; if ({ready, busy, done} !== 3'b100) $display("FAIL basic_return_ready got %b want 100", {ready, busy, done}); else n_pass++;
    endtask

    task automatic test_carry();
        exp_t e; int cyc, bcnt; bit to;
        launch(16'h9999, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0));
        wait_done(cyc, bcnt, to);
        e = exp_q.pop_front();
        n_chk++; if (to || sum !== e.sum || cout !== e.cout) $display("FAIL carry_ripple got %h/%b want %h/%b", sum, cout, e.sum, e.cout); else n_pass++;
        launch(16'h9999, 16'h9999, 1'b1, mk(16'h9999, 1'b1, 1'b0));
        wait_done(cyc, bcnt, to);
        e = exp_q.pop_front();
        n_chk++; if (to || sum !== e.sum || cout !== e.cout) $display("FAIL carry_max got %h/%b want %h/%b", sum, cout, e.sum, e.cout); else n_pass++;
    endtask

    task automatic test_err();
        exp_t e; int cyc, bcnt; bit to;
        launch(16'h000A, 16'h0000, 1'b0, mk(16'h0010, 1'b0, 1'b1));
        wait_done(cyc, bcnt, to);
        e = exp_q.pop_front();
        n_chk++; if (to || err !== e.err) $display("FAIL err_flag got %b want %b", err, e.err); else n_pass++;
        n_chk++; if (sum !== e.sum || cout !== e.cout) $display("FAIL err_sum got %h/%b want %h/%b", sum, cout, e.sum, e.cout); else n_pass++;
        launch(16'h0042, 16'h0057, 1'b0, model(16'h0042, 16'h0057, 1'b0));
        wait_done(cyc, bcnt, to);
        e = exp_q.pop_front();
        n_chk++; if (to || err !== 1'b0 || sum !== e.sum) $display("FAIL err_clear got err=%b sum=%h want 0/%h", err, sum, e.sum); else n_pass++;
    endtask

    task automatic test_ignore_start();
        exp_t e; int cyc, bcnt; bit to;
        launch(16'h1234, 16'h5678, 1'b0, mk(16'h6912, 1'b0, 1'b0));
        a = 16'h9999; b = 16'h9999; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bcnt, to);
        e = exp_q.pop_front();
        n_chk++; if (to || sum !== e.sum || cout !== e.cout) $display("FAIL ignore_run got %h/%b want %h/%b", sum, cout, e.sum, e.cout); else n_pass++;
        a = 16'h0808; b = 16'h0101; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        n_chk++; if (ready !== 1'b1 || busy !== 1'b0) $display("FAIL ignore_done_accept got ready/busy %b want 10", {ready, busy}); else n_pass++;
        exp_q.push_back(model(16'h0808, 16'h0101, 1'b0));
        @(negedge clk);
        start = 1'b0;
        n_chk++; if (busy !== 1'b1) $display("FAIL ignore_held_start got busy %b want 1", busy); else n_pass++;
        wait_done(cyc, bcnt, to);
        e = exp_q.pop_front();
        n_chk++; if (to || sum !== e.sum || cout !== e.cout) $display("FAIL ignore_held_result got %h/%b want %h/%b", sum, cout, e.sum, e.cout); else n_pass++;
        repeat (2) @(negedge clk);
        n_chk++; if (ready !== 1'b1) $display("FAIL ignore_single_accept got ready %b want 1", ready); else n_pass++;
    endtask

    task automatic test_reset_abort();
        exp_t e; int cyc, bcnt; bit to; int seen_done = 0;
        launch(16'h1234, 16'h5678, 1'b0, mk(16'h6912, 1'b0, 1'b0));
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk++; if ({ready, busy, done} !== 3'b100) $display("FAIL abort_state got %b want 100", {ready, busy, done}); else n_pass++;
        n_chk++; if ({sum, cout, err} !== 18'd0) $display("FAIL abort_clear got sum=%h cout=%b err=%b want 0", sum, cout, err); else n_pass++;
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
        end
        n_chk++; if (seen_done !== 0) $display("FAIL abort_no_done got %0d done cycles want 0", seen_done); else n_pass++;
        launch(16'h0505, 16'h0505, 1'b0, mk(16'h1010, 1'b0, 1'b0));
        wait_done(cyc, bcnt, to);
        e = exp_q.pop_front();
        n_chk++; if (to || sum !== e.sum || cout !== e.cout) $display("FAIL abort_recover got %h/%b want %h/%b", sum, cout, e.sum, e.cout); else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t e; int cyc, bcnt; bit to;
        launch(16'h0000, 16'h0000, 1'b1, mk(16'h0001, 1'b0, 1'b0));
        wait_done(cyc, bcnt, to);
        e = exp_q.pop_front();
        n_chk++; if (to || sum !== e.sum) $display("FAIL b2b_first got %h want %h", sum, e.sum); else n_pass++;
        @(negedge clk);
        a = 16'h4321; b = 16'h1111; cin = 1'b0; start = 1'b1;
        n_chk++; if (ready !== 1'b1 || sum !== 16'h0001) $display("FAIL b2b_hold got ready=%b sum=%h want 1/0001", ready, sum); else n_pass++;
        exp_q.push_back(model(16'h4321, 16'h1111, 1'b0));
        @(negedge clk);
        start = 1'b0;
        n_chk++; if (busy !== 1'b1 || sum !== 16'h0000) $display("FAIL b2b_accept got busy=%b sum=%h want 1/0000", busy, sum); else n_pass++;
        wait_done(cyc, bcnt, to);
        e = exp_q.pop_front();
        n_chk++; if (to || sum !== e.sum || cout !== e.cout) $display("FAIL b2b_second got %h/%b want %h/%b", sum, cout, e.sum, e.cout); else n_pass++;
    endtask

    task automatic test_random();
        exp_t e; int cyc, bcnt; bit to;
        logic [15:0] va, vb; logic vc;
        for (int k = 0; k < 6; k++) begin
            va = to_bcd(int'($urandom_range(0, 9999)));
            vb = to_bcd(int'($urandom_range(0, 9999)));
            vc = 1'($urandom_range(0, 1));
            launch(va, vb, vc, model(va, vb, vc));
            wait_done(cyc, bcnt, to);
            e = exp_q.pop_front();
            n_chk++; if (to || sum !== e.sum || cout !== e.cout || err !== 1'b0) $display("FAIL random_%0d %h+%h+%b got %h/%b/%b want %h/%b/0", k, va, vb, vc, sum, cout, err, e.sum, e.cout); else n_pass++;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_err();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
